initial_try6_rx_echo: RTL and testbench

UART receive-and-echo block for a 12 MHz system clock at 9600 baud, 8N1 framing. It samples the serial line `data`, captures each complete frame, flags a good byte on `ready` for one cycle, and retransmits that byte on `tx`. It sits directly behind the board's serial input pin. It also exposes its receiver internals (`data_store`, `bit_count`, `state`) for debug.

---
 rtl/initial_try6_rx_echo.sv | 175 +++++++++++++++++
 tb/tb_initial_try6_rx_echo.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/initial_try6_rx_echo.sv
// rtl/initial_try6_rx_echo.sv - 8N1 UART receiver that echoes each good byte back on tx
module initial_try6_rx_echo #(
   parameter int CLKS_PER_BIT = 1250,
   parameter int HALF_BIT     = 625
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic       data,
   output logic       ready,
   output logic       tx,
   output logic [9:0] data_store,
   output logic [3:0] bit_count,
   output logic [1:0] state,
   output logic       busy,
   output logic       idle
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_e;

   localparam logic [10:0] BIT_LAST  = 11'(CLKS_PER_BIT - 1);
   localparam logic [10:0] HALF_LAST = 11'(HALF_BIT - 1);

   logic        sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
   rx_state_e   rx_state_q, rx_state_d;
   logic [10:0] baud_q, baud_d;
   logic [3:0]  bit_count_q, bit_count_d;
   logic [9:0]  data_store_q, data_store_d;
   logic        ready_q, ready_d;
   logic        tx_q, tx_d;
   logic        busy_q, busy_d;
   logic [10:0] tx_cnt_q, tx_cnt_d;
   logic [3:0]  tx_bits_q, tx_bits_d;
   logic [8:0]  tx_shift_q, tx_shift_d;
   logic        idle_q, idle_d;

   // Synchronizer and edge history preset high so an idle line at reset is not an edge
   always_ff @(posedge clk) begin
      if (!nrst) begin
         sync1_q      <= 1'b1;
         sync2_q      <= 1'b1;
         prev_q       <= 1'b1;
         rx_state_q   <= IDLE;
         baud_q       <= '0;
         bit_count_q  <= '0;
         data_store_q <= '0;
         ready_q      <= 1'b0;
         tx_q         <= 1'b1;
         busy_q       <= 1'b0;
         tx_cnt_q     <= '0;
         tx_bits_q    <= '0;
         tx_shift_q   <= '1;
         idle_q       <= 1'b1;
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         prev_q       <= prev_d;
         rx_state_q   <= rx_state_d;
         baud_q       <= baud_d;
         bit_count_q  <= bit_count_d;
         data_store_q <= data_store_d;
         ready_q      <= ready_d;
         tx_q         <= tx_d;
         busy_q       <= busy_d;
         tx_cnt_q     <= tx_cnt_d;
         tx_bits_q    <= tx_bits_d;
         tx_shift_q   <= tx_shift_d;
         idle_q       <= idle_d;
      end
   end

   always_comb begin
      sync1_d      = data;
      sync2_d      = sync1_q;
      prev_d       = sync2_q;
      rx_state_d   = rx_state_q;
      baud_d       = baud_q;
      bit_count_d  = bit_count_q;
      data_store_d = data_store_q;
      ready_d      = 1'b0;

      case (rx_state_q)
         IDLE: begin
            if (prev_q && !sync2_q) begin
               baud_d      = '0;
               bit_count_d = '0;
               rx_state_d  = START;
            end
         end
         START: begin
            if (baud_q == HALF_LAST) begin
               baud_d = '0;
               if (!sync2_q) begin
                  data_store_d[0] = 1'b0;
                  bit_count_d     = 4'd1;
                  rx_state_d      = DATA;
               end else begin
                  rx_state_d = IDLE;
               end
            end else begin
               baud_d = baud_q + 11'd1;
            end
         end
         DATA: begin
            if (baud_q == BIT_LAST) begin
               baud_d                    = '0;
               data_store_d[bit_count_q] = sync2_q;
               bit_count_d               = bit_count_q + 4'd1;
               if (bit_count_q == 4'd8) rx_state_d = STOP;
            end else begin
               baud_d = baud_q + 11'd1;
            end
         end
         STOP: begin
            // Leaving mid-stop-bit lets a back-to-back start edge be caught
            if (baud_q == BIT_LAST) begin
               baud_d          = '0;
               data_store_d[9] = sync2_q;
               ready_d         = sync2_q;
               bit_count_d     = '0;
               rx_state_d      = IDLE;
            end else begin
               baud_d = baud_q + 11'd1;
            end
         end
         default: rx_state_d = IDLE;
      endcase
   end

   always_comb begin
      tx_d       = tx_q;
      busy_d     = busy_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bits_d  = tx_bits_q;
      tx_shift_d = tx_shift_q;

      if (busy_q) begin
         if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_d = '0;
            if (tx_bits_q == 4'd9) begin
               busy_d = 1'b0;
               tx_d   = 1'b1;
            end else begin
               tx_bits_d  = tx_bits_q + 4'd1;
               tx_d       = tx_shift_q[0];
               tx_shift_d = {1'b1, tx_shift_q[8:1]};
            end
         end else begin
            tx_cnt_d = tx_cnt_q + 11'd1;
         end
      end else if (ready_q) begin
         // Shift register holds the data byte with the stop bit parked on top
         busy_d     = 1'b1;
         tx_d       = 1'b0;
         tx_cnt_d   = '0;
         tx_bits_d  = '0;
         tx_shift_d = {1'b1, data_store_q[8:1]};
      end

      idle_d = (rx_state_d == IDLE) && !busy_d;
   end

   assign ready      = ready_q;
   assign tx         = tx_q;
   assign data_store = data_store_q;
   assign bit_count  = bit_count_q;
   assign state      = rx_state_q;
   assign busy       = busy_q;
   assign idle       = idle_q;

endmodule

// File: tb/tb_initial_try6_rx_echo.sv
// tb/tb_initial_try6_rx_echo.sv - directed bench for the UART receive-and-echo block
module tb_initial_try6_rx_echo;

   localparam int CPB = 16;
   localparam int HB  = 8;

   logic       clk = 1'b0;
   logic       nrst = 1'b0;
   logic       data = 1'b1;
   logic       ready, tx, busy, idle;
   logic [9:0] data_store;
   logic [3:0] bit_count;
   logic [1:0] state;

   always #5 clk = ~clk;

   initial_try6_rx_echo #(.CLKS_PER_BIT(CPB), .HALF_BIT(HB)) dut (
      .clk(clk), .nrst(nrst), .data(data), .ready(ready), .tx(tx),
      .data_store(data_store), .bit_count(bit_count), .state(state),
      .busy(busy), .idle(idle)
   );

   int tests = 0;
   int fails = 0;

   int cyc = 0, ready_cnt = 0, ready_run = 0, ready_max = 0, ready_cyc = 0;
   int busy_run = 0, last_busy_len = 0, tx_low_cnt = 0, tx_start_cyc = 0;
   int dec_cnt = 0, dec_idx = 0;
   bit dec_on = 1'b0;
   logic [7:0] dec_byte = 8'h00;
   logic [7:0] echo_q[$];
   logic       echo_stop_q[$];

   // Monitor: ready pulses, busy length, and a line decoder for the echo
   always @(negedge clk) begin
      cyc++;
      if (nrst !== 1'b1) begin
         dec_on    = 1'b0;
         ready_run = 0;
         busy_run  = 0;
      end else begin
         if (ready === 1'b1) begin
            ready_cnt++;
            ready_run++;
            ready_cyc = cyc;
            if (ready_run > ready_max) ready_max = ready_run;
         end else begin
            ready_run = 0;
         end
         if (busy === 1'b1) busy_run++;
         else if (busy_run != 0) begin
            last_busy_len = busy_run;
            busy_run = 0;
         end
         if (tx === 1'b0) tx_low_cnt++;
         if (!dec_on) begin
            if (tx === 1'b0) begin
               dec_on = 1'b1;
               dec_cnt = 0;
               tx_start_cyc = cyc;
            end
         end else begin
            dec_cnt++;
            if (dec_cnt >= CPB + CPB/2 && (dec_cnt - CPB/2) % CPB == 0) begin
               dec_idx = (dec_cnt - CPB/2) / CPB;
               if (dec_idx <= 8) dec_byte[3'(dec_idx - 1)] = tx;
               else begin
                  echo_q.push_back(dec_byte);
                  echo_stop_q.push_back(tx);
                  dec_on = 1'b0;
               end
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      logic [9:0] f;
      f = {stop_bit, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         data = f[i];
         repeat (CPB) @(negedge clk);
      end
      data = 1'b1;
   endtask

   task automatic wait_tx_done(input string tag);
      int n;
      n = 0;
      while (busy === 1'b1 && n < 20 * CPB) begin
         @(negedge clk);
         n++;
      end
      check(tag, {31'd0, busy}, 32'd0);
   endtask

   task automatic frame_and_check(input logic [7:0] b, input string tag);
      int r0, e0;
      r0 = ready_cnt;
      e0 = echo_q.size();
      send_frame(b, 1'b1);
      check({tag, "_ready"}, ready_cnt - r0, 1);
      check({tag, "_store"}, data_store, {1'b1, b, 1'b0});
      wait_tx_done({tag, "_txdone"});
      repeat (CPB) @(negedge clk);
      check({tag, "_echo_cnt"}, echo_q.size() - e0, 1);
      check({tag, "_echo"}, (echo_q.size() > e0) ? echo_q[e0] : 8'hxx, b);
   endtask

   initial begin
      int r0, e0, t0;
      logic [7:0] last_b, rb;

      nrst = 1'b0;
      data = 1'b1;
      repeat (20) @(negedge clk);
      check("rst_ready", ready, 0);
      check("rst_tx", tx, 1);
      check("rst_store", data_store, 0);
      check("rst_bitcnt", bit_count, 0);
      check("rst_state", state, 0);
      check("rst_busy", busy, 0);
      check("rst_idle", idle, 1);
      nrst = 1'b1;
      repeat (5) @(negedge clk);
      check("rel_state", state, 0);
      check("rel_tx", tx, 1);
      check("rel_idle", idle, 1);

      // Single byte 0x53
      r0 = ready_cnt;
      e0 = echo_q.size();
      send_frame(8'h53, 1'b1);
      check("b53_ready", ready_cnt - r0, 1);
      check("b53_store", data_store, 10'b1_0101_0011_0);
      check("b53_tx_lat", tx_start_cyc - ready_cyc, 1);
      wait_tx_done("b53_txdone");
      repeat (2) @(negedge clk);
      check("b53_busy_len", last_busy_len, 10 * CPB);
      check("b53_echo", (echo_q.size() > e0) ? echo_q[e0] : 8'hxx, 8'h53);
      check("b53_echo_stop", (echo_stop_q.size() > e0) ? echo_stop_q[e0] : 1'bx, 1);
      check("b53_tx_idle", tx, 1);
      check("b53_idle", idle, 1);

      // Named bytes then random bytes with idle gaps
      frame_and_check(8'h6E, "b6e");
      frame_and_check(8'h61, "b61");
      frame_and_check(8'h70, "b70");
      last_b = 8'h70;
      for (int i = 0; i < 100; i++) begin
         rb = 8'($urandom_range(0, 255));
         frame_and_check(rb, $sformatf("rnd%0d", i));
         last_b = rb;
         repeat ($urandom_range(0, 3 * CPB)) @(negedge clk);
      end

      // Line held high for five bit times
      r0 = ready_cnt;
      repeat (5 * CPB) @(negedge clk);
      check("high_state", state, 0);
      check("high_ready", ready_cnt - r0, 0);
      check("high_store", data_store, {1'b1, last_b, 1'b0});

      // Short glitch: edge-to-START latency, then back to IDLE
      r0 = ready_cnt;
      data = 1'b0;
      repeat (2) @(negedge clk);
      check("edge_lat2", state, 0);
      @(negedge clk);
      check("edge_lat3", state, 1);
      repeat (2) @(negedge clk);
      data = 1'b1;
      repeat (HB + 6) @(negedge clk);
      check("glitch_state", state, 0);
      check("glitch_ready", ready_cnt - r0, 0);
      check("glitch_store", data_store, {1'b1, last_b, 1'b0});

      // Framing error
      r0 = ready_cnt;
      t0 = tx_low_cnt;
      send_frame(8'hA5, 1'b0);
      repeat (2 * CPB) @(negedge clk);
      check("ferr_store", data_store, {1'b0, 8'hA5, 1'b0});
      check("ferr_ready", ready_cnt - r0, 0);
      check("ferr_tx", tx_low_cnt - t0, 0);
      check("ferr_busy", busy, 0);
      check("ferr_state", state, 0);

      // Back-to-back: second ready lands while the first echo is still busy
      r0 = ready_cnt;
      e0 = echo_q.size();
      send_frame(8'h3C, 1'b1);
      send_frame(8'hC3, 1'b1);
      check("b2b_ready", ready_cnt - r0, 2);
      check("b2b_store", data_store, {1'b1, 8'hC3, 1'b0});
      wait_tx_done("b2b_txdone");
      repeat (CPB) @(negedge clk);
      check("b2b_echo_cnt", echo_q.size() - e0, 1);
      check("b2b_echo", (echo_q.size() > e0) ? echo_q[e0] : 8'hxx, 8'h3C);

      // Reset mid-receive while an echo is in flight
      send_frame(8'h96, 1'b1);
      data = 1'b0;
      repeat (3 * CPB) @(negedge clk);
      check("mid_state", state, 2);
      check("mid_busy", busy, 1);
      nrst = 1'b0;
      data = 1'b1;
      @(negedge clk);
      check("mrst_state", state, 0);
      check("mrst_bitcnt", bit_count, 0);
      check("mrst_tx", tx, 1);
      check("mrst_busy", busy, 0);
      check("mrst_store", data_store, 0);
      check("mrst_idle", idle, 1);
      @(negedge clk);
      nrst = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      check("post_rst_state", state, 0);

      frame_and_check(8'h5A, "recover");
      check("ready_width", ready_max, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
